// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one sequential divider among NREQ requesters.
// Optional divider watchdog is enabled with `define DIV_TIMEOUT_EN.
module div_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_quotient,
    output logic [WIDTH-1:0]      rsp_remainder,
    output logic                  rsp_div0,
    output logic                  rsp_err,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_done,
    input  logic [WIDTH-1:0]      div_quotient,
    input  logic [WIDTH-1:0]      div_remainder
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("div_share_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    grant;
    logic [IW-1:0]    rr_nxt;
    logic             found;
    logic             accept;
    logic             rsp_hs;
    logic             done_hit;
    logic             tmo_hit;
    logic             sel_zero;
    logic [WIDTH-1:0] sel_dvd;
    logic [WIDTH-1:0] sel_dvs;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                grant = IW'(j);
            end
        end
    end

    assign sel_dvd  = req_dividend[int'(grant)*WIDTH +: WIDTH];
    assign sel_dvs  = req_divisor[int'(grant)*WIDTH +: WIDTH];
    assign sel_zero = (sel_dvs == '0);
    assign rr_nxt   = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;

    assign accept   = (state == S_IDLE) && found;
    assign done_hit = (state == S_WAIT) && div_done;
    assign rsp_hs   = (state == S_RESP) && rsp_ready[idx];

    assign div_start = (state == S_LAUNCH);

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (state == S_RESP) rsp_valid[idx] = 1'b1;
    end

`ifdef DIV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit = (state == S_WAIT) && !div_done &&
                     (tmo_cnt == TW'(TIMEOUT - 1));
    assign rsp_err = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == S_LAUNCH) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (accept || done_hit) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = sel_zero ? S_RESP : S_LAUNCH;
            end
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_hit || tmo_hit) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_hs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= '0;
            idx          <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (accept) begin
            rr_ptr       <= rr_nxt;
            idx          <= grant;
            div_dividend <= sel_dvd;
            div_divisor  <= sel_dvs;
        end
    end

    // Zero divisors are answered here and never reach the divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div0      <= 1'b0;
        end else if (accept && sel_zero) begin
            rsp_quotient  <= '1;
            rsp_remainder <= sel_dvd;
            rsp_div0      <= 1'b1;
        end else if (done_hit) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_div0      <= 1'b0;
        end else if (tmo_hit) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div0      <= 1'b0;
        end
    end

endmodule
